// File: rtl/if_id_queue.sv
// IF/ID circular queue: buffers up to DEPTH fetched {instruction, PC+4} entries
// between fetch and decode. Optional stall counter enabled by IFQ_STALL_CNT_EN.
module if_id_queue #(
  parameter int WIDTH = 32,
  parameter int PC_W  = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_ir,
  input  logic [PC_W-1:0]          in_pc4,
  input  logic                     flush,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         IR_D,
  output logic [PC_W-1:0]          PC4_D,
  output logic [PC_W-1:0]          PC8_D,
  output logic [$clog2(DEPTH):0]   count
`ifdef IFQ_STALL_CNT_EN
  ,
  output logic [31:0]              stall_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] ir_mem_q  [DEPTH];
  logic [PC_W-1:0]  pc4_mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop;

  // Handshake flags depend on registered occupancy only, so no input reaches an output.
  assign in_ready  = (count_q != FULL);
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  always_comb begin
    // NOTE: every signal gets a default first so no path through this block infers a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; pointers and count alone define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      ir_mem_q[wr_ptr_q]  <= in_ir;
      pc4_mem_q[wr_ptr_q] <= in_pc4;
    end
  end

  assign IR_D  = out_valid ? ir_mem_q[rd_ptr_q]  : '0;
  assign PC4_D = out_valid ? pc4_mem_q[rd_ptr_q] : '0;
  assign PC8_D = out_valid ? (pc4_mem_q[rd_ptr_q] + PC_W'(4)) : '0;
  assign count = count_q;

`ifdef IFQ_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Counts fetch cycles blocked by a full queue; saturates, survives flush.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (in_valid & ~in_ready & ~flush & (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue (DEPTH=2) against a queue-based reference
// model; exercises the stall counter when IFQ_STALL_CNT_EN is defined.
module tb_if_id_queue;

  localparam int WIDTH = 32;
  localparam int PC_W  = 32;
  localparam int DEPTH = 2;

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_ir;
  logic [PC_W-1:0]   in_pc4;
  logic              flush;
  logic              out_ready;
  logic              out_valid;
  logic [WIDTH-1:0]  IR_D;
  logic [PC_W-1:0]   PC4_D;
  logic [PC_W-1:0]   PC8_D;
  logic [$clog2(DEPTH):0] count;
`ifdef IFQ_STALL_CNT_EN
  logic [31:0]       stall_cnt;
`endif

  if_id_queue #(.WIDTH(WIDTH), .PC_W(PC_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ir     (in_ir),
    .in_pc4    (in_pc4),
    .flush     (flush),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .IR_D      (IR_D),
    .PC4_D     (PC4_D),
    .PC8_D     (PC8_D),
    .count     (count)
`ifdef IFQ_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] ir;
    logic [PC_W-1:0]  pc4;
  } ent_t;

  ent_t        model_q[$];
  logic [31:0] model_stall;
  int          n_cmp;
  int          n_err;

  function automatic int exp_count();
    return model_q.size();
  endfunction

  function automatic logic exp_ovalid();
    return model_q.size() != 0;
  endfunction

  function automatic logic exp_iready();
    return model_q.size() != DEPTH;
  endfunction

  function automatic logic [WIDTH-1:0] exp_ir();
    return (model_q.size() != 0) ? model_q[0].ir : '0;
  endfunction

  function automatic logic [PC_W-1:0] exp_pc4();
    return (model_q.size() != 0) ? model_q[0].pc4 : '0;
  endfunction

  function automatic logic [PC_W-1:0] exp_pc8();
    return (model_q.size() != 0) ? model_q[0].pc4 + 32'd4 : '0;
  endfunction

  // Drive one cycle's inputs (called at a falling edge), update the model at the
  // rising edge from the pre-edge occupancy, and return at the next falling edge.
  task automatic drive_cycle(input bit rst, input bit v, input logic [WIDTH-1:0] ir,
                             input logic [PC_W-1:0] pc4, input bit ordy, input bit fl);
    bit full, empty;
    reset = rst; in_valid = v; in_ir = ir; in_pc4 = pc4; out_ready = ordy; flush = fl;
    @(posedge clk);
    full  = (model_q.size() == DEPTH);
    empty = (model_q.size() == 0);
    if (rst) begin
      model_q.delete();
      model_stall = '0;
    end else begin
      if (v && full && !fl && model_stall != 32'hFFFF_FFFF) model_stall = model_stall + 1;
      if (fl) model_q.delete();
      else begin
        if (ordy && !empty) void'(model_q.pop_front());
        if (v && !full) model_q.push_back('{ir: ir, pc4: pc4});
      end
    end
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    drive_cycle(1, 0, '0, '0, 0, 0);
    drive_cycle(1, 0, '0, '0, 0, 0);
    n_cmp++; if (count !== 2'd0)  begin n_err++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1)  begin n_err++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_cmp++; if (IR_D !== 32'h0)   begin n_err++; $display("FAIL reset_IR_D: got %h expected 0", IR_D); end
    n_cmp++; if (PC4_D !== 32'h0)  begin n_err++; $display("FAIL reset_PC4_D: got %h expected 0", PC4_D); end
    n_cmp++; if (PC8_D !== 32'h0)  begin n_err++; $display("FAIL reset_PC8_D: got %h expected 0", PC8_D); end
`ifdef IFQ_STALL_CNT_EN
    n_cmp++; if (stall_cnt !== 32'h0) begin n_err++; $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt); end
`endif
  endtask

  task automatic test_fill_stall();
    drive_cycle(0, 1, 32'h8C01_0004, 32'h3004, 0, 0);
    n_cmp++; if (IR_D !== 32'h8C01_0004) begin n_err++; $display("FAIL fill_first_visible: got %h expected 8c010004", IR_D); end
    drive_cycle(0, 1, 32'h0000_0000, 32'h3008, 0, 0);
    drive_cycle(0, 1, 32'hDEAD_BEEF, 32'h300C, 0, 0);
    n_cmp++; if (count !== 2'd2)  begin n_err++; $display("FAIL fill_count: got %0d expected 2", count); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL fill_in_ready: got %b expected 0", in_ready); end
    n_cmp++; if (IR_D !== 32'h8C01_0004) begin n_err++; $display("FAIL fill_IR_D: got %h expected 8c010004", IR_D); end
    n_cmp++; if (PC4_D !== 32'h3004) begin n_err++; $display("FAIL fill_PC4_D: got %h expected 3004", PC4_D); end
    n_cmp++; if (PC8_D !== 32'h3008) begin n_err++; $display("FAIL fill_PC8_D: got %h expected 3008", PC8_D); end
  endtask

  task automatic test_pop_empty();
    drive_cycle(0, 0, '0, '0, 1, 0);
    n_cmp++; if (PC4_D !== 32'h3008) begin n_err++; $display("FAIL pop_second_PC4_D: got %h expected 3008", PC4_D); end
    n_cmp++; if (count !== 2'd1) begin n_err++; $display("FAIL pop_count1: got %0d expected 1", count); end
    drive_cycle(0, 0, '0, '0, 1, 0);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL pop_out_valid: got %b expected 0", out_valid); end
    n_cmp++; if (IR_D !== 32'h0) begin n_err++; $display("FAIL pop_IR_D: got %h expected 0", IR_D); end
    n_cmp++; if (PC8_D !== 32'h0) begin n_err++; $display("FAIL pop_PC8_D: got %h expected 0", PC8_D); end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] ir;
    drive_cycle(0, 1, 32'h1111_0000, 32'h4000, 0, 0);
    for (int i = 0; i < 4; i++) begin
      ir = 32'h2222_0000 + 32'(i);
      drive_cycle(0, 1, ir, 32'h5000 + 32'(4 * i), 1, 0);
      n_cmp++; if (count !== 2'd1) begin n_err++; $display("FAIL b2b_count[%0d]: got %0d expected 1", i, count); end
      n_cmp++; if (IR_D !== ir) begin n_err++; $display("FAIL b2b_IR_D[%0d]: got %h expected %h", i, IR_D, ir); end
      n_cmp++; if (PC8_D !== 32'h5004 + 32'(4 * i)) begin
        n_err++; $display("FAIL b2b_PC8_D[%0d]: got %h expected %h", i, PC8_D, 32'h5004 + 32'(4 * i));
      end
    end
    drive_cycle(0, 0, '0, '0, 1, 0);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_flush();
    drive_cycle(0, 1, 32'hA000_0001, 32'h6004, 0, 0);
    drive_cycle(0, 1, 32'hA000_0002, 32'h6008, 0, 0);
    drive_cycle(0, 1, 32'hBAD0_BAD0, 32'h600C, 0, 1);
    n_cmp++; if (count !== 2'd0) begin n_err++; $display("FAIL flush_count: got %0d expected 0", count); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_out_valid: got %b expected 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL flush_in_ready: got %b expected 1", in_ready); end
    drive_cycle(0, 0, '0, '0, 1, 0);
    n_cmp++; if (IR_D !== 32'h0) begin n_err++; $display("FAIL flush_dropped_IR_D: got %h expected 0", IR_D); end
    drive_cycle(0, 1, 32'hC000_0003, 32'h7004, 0, 0);
    n_cmp++; if (IR_D !== 32'hC000_0003) begin n_err++; $display("FAIL flush_refill_IR_D: got %h expected c0000003", IR_D); end
    drive_cycle(0, 0, '0, '0, 1, 0);
  endtask

`ifdef IFQ_STALL_CNT_EN
  task automatic test_stall_cnt();
    drive_cycle(1, 0, '0, '0, 0, 0);
    drive_cycle(0, 1, 32'h1, 32'h4, 0, 0);
    drive_cycle(0, 1, 32'h2, 32'h8, 0, 0);
    for (int i = 0; i < 5; i++) drive_cycle(0, 1, 32'h3, 32'hC, 0, 0);
    n_cmp++; if (stall_cnt !== 32'd5) begin n_err++; $display("FAIL stall_after5: got %0d expected 5", stall_cnt); end
    drive_cycle(0, 1, 32'h4, 32'h10, 0, 1);
    drive_cycle(0, 1, 32'h5, 32'h14, 0, 0);
    drive_cycle(0, 1, 32'h6, 32'h18, 0, 0);
    for (int i = 0; i < 3; i++) drive_cycle(0, 1, 32'h7, 32'h1C, 0, 0);
    n_cmp++; if (stall_cnt !== 32'd8) begin n_err++; $display("FAIL stall_after8: got %0d expected 8", stall_cnt); end
    drive_cycle(1, 0, '0, '0, 0, 0);
    n_cmp++; if (stall_cnt !== 32'd0) begin n_err++; $display("FAIL stall_reset: got %0d expected 0", stall_cnt); end
  endtask
`endif

  task automatic test_random();
    bit rst, v, ordy, fl;
    logic [PC_W-1:0] pc4;
    for (int i = 0; i < 400; i++) begin
      rst  = ($urandom_range(0, 99) == 0);
      fl   = ($urandom_range(0, 19) == 0);
      v    = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      pc4  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3)) : $urandom;
      drive_cycle(rst, v, $urandom, pc4, ordy, fl);
      n_cmp++; if (count !== exp_count()) begin n_err++; $display("FAIL rnd_count[%0d]: got %0d expected %0d", i, count, exp_count()); end
      n_cmp++; if (out_valid !== exp_ovalid()) begin n_err++; $display("FAIL rnd_out_valid[%0d]: got %b expected %b", i, out_valid, exp_ovalid()); end
      n_cmp++; if (in_ready !== exp_iready()) begin n_err++; $display("FAIL rnd_in_ready[%0d]: got %b expected %b", i, in_ready, exp_iready()); end
      n_cmp++; if (IR_D !== exp_ir()) begin n_err++; $display("FAIL rnd_IR_D[%0d]: got %h expected %h", i, IR_D, exp_ir()); end
      n_cmp++; if (PC4_D !== exp_pc4()) begin n_err++; $display("FAIL rnd_PC4_D[%0d]: got %h expected %h", i, PC4_D, exp_pc4()); end
      n_cmp++; if (PC8_D !== exp_pc8()) begin n_err++; $display("FAIL rnd_PC8_D[%0d]: got %h expected %h", i, PC8_D, exp_pc8()); end
`ifdef IFQ_STALL_CNT_EN
      n_cmp++; if (stall_cnt !== model_stall) begin n_err++; $display("FAIL rnd_stall_cnt[%0d]: got %0d expected %0d", i, stall_cnt, model_stall); end
`endif
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0; model_stall = '0;
    reset = 1'b1; in_valid = 1'b0; in_ir = '0; in_pc4 = '0; flush = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_fill_stall();
    test_pop_empty();
    test_back_to_back();
    test_flush();
`ifdef IFQ_STALL_CNT_EN
    test_stall_cnt();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
